key_debounce_bank: RTL

Parametrised multi-channel successor to the single-key debouncer. It filters CHANNELS raw active-low key inputs with per-channel hysteresis counters and a shared tick strobe. For each channel it produces a debounced level, one-cycle press/release event pulses and a long-press indication. It sits between board push-buttons and the control FSMs, replacing per-key debounce instances.

---
 rtl/key_debounce_bank_pkg.sv | 20 ++
 rtl/key_debounce_bank_if.sv | 24 ++
 rtl/key_debounce_channel.sv | 110 +++++++++++
 rtl/key_debounce_bank.sv | 64 ++++++
 4 files changed

// File: rtl/key_debounce_bank_pkg.sv
// Purpose : shared FSM encoding and default parameters for the key debounce bank.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package key_debounce_bank_pkg;

    // Per-channel debounce state. IDLE/ARMING report released, PRESSED/DISARMING report pressed.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        PRESSED   = 2'd2,
        DISARMING = 2'd3
    } deb_state_t;

    localparam int DEF_CHANNELS   = 4;
    localparam int DEF_CNT_W      = 16;
    localparam int DEF_THRESHOLD  = 255;
    localparam int DEF_HOLD_W     = 16;
    localparam int DEF_HOLD_TICKS = 1000;

endpackage

// File: rtl/key_debounce_bank_if.sv
// Purpose : key bank bus - raw keys and tick strobe in, debounced level/events out.
// Latency : n/a (wiring only).
// Backpressure: none; outputs are free-running levels and one-cycle pulses.
// Ports   : master = key source / consumer side, slave = debounce bank.
interface key_debounce_bank_if #(
    parameter int CHANNELS = key_debounce_bank_pkg::DEF_CHANNELS
);
    logic                tickEn;
    logic [CHANNELS-1:0] keyBounce;
    logic [CHANNELS-1:0] keyDeBounce;
    logic [CHANNELS-1:0] pressPulse;
    logic [CHANNELS-1:0] releasePulse;
    logic [CHANNELS-1:0] holdActive;

    modport master (
        output tickEn, keyBounce,
        input  keyDeBounce, pressPulse, releasePulse, holdActive
    );

    modport slave (
        input  tickEn, keyBounce,
        output keyDeBounce, pressPulse, releasePulse, holdActive
    );
endinterface

// File: rtl/key_debounce_channel.sv
// Purpose : one-key hysteresis debouncer with press/release pulses and long-press flag.
// Latency : press/release reported on the THRESHOLD-th qualifying tick edge.
// Backpressure: none; state only advances on edges where tick_en is 1.
// Ports   : clk, rst_n, tick_en, key_raw (0 = pressed) in;
//           key_level (0 = pressed), press_pulse, release_pulse, hold_active out.
module key_debounce_channel
    import key_debounce_bank_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int THRESHOLD  = DEF_THRESHOLD,
    parameter int HOLD_W     = DEF_HOLD_W,
    parameter int HOLD_TICKS = DEF_HOLD_TICKS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_en,
    input  logic key_raw,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic hold_active
);
    localparam logic [CNT_W-1:0]  THR  = CNT_W'(THRESHOLD);
    localparam logic [HOLD_W-1:0] HOLD = HOLD_W'(HOLD_TICKS);

    deb_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              level_nxt, press_nxt, release_nxt, hold_act_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            hold_cnt      <= '0;
            key_level     <= 1'b1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            hold_active   <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            hold_cnt      <= hold_nxt;
            key_level     <= level_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            hold_active   <= hold_act_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        hold_nxt     = hold_cnt;
        level_nxt    = key_level;
        press_nxt    = 1'b0;   // pulses self-clear every clock, tick or not
        release_nxt  = 1'b0;
        hold_act_nxt = hold_active;
        if (tick_en) begin
            case (state)
                IDLE, ARMING: begin
                    if (!key_raw) begin
                        if (cnt == THR - 1'b1) begin
                            state_nxt = PRESSED;
                            cnt_nxt   = THR;
                            level_nxt = 1'b0;
                            press_nxt = 1'b1;
                        end else begin
                            state_nxt = ARMING;
                            cnt_nxt   = cnt + 1'b1;
                        end
                    end else begin
                        // any bounce discards all accumulated press credit
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end
                PRESSED, DISARMING: begin
                    // long-press timer runs across DISARMING too, saturating at HOLD
                    if (hold_cnt != HOLD) begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                    if (hold_nxt == HOLD) begin
                        hold_act_nxt = 1'b1;
                    end
                    if (key_raw) begin
                        if (cnt == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                            state_nxt    = IDLE;
                            cnt_nxt      = '0;
                            level_nxt    = 1'b1;
                            release_nxt  = 1'b1;
                            hold_nxt     = '0;
                            hold_act_nxt = 1'b0;
                        end else begin
                            state_nxt = DISARMING;
                            cnt_nxt   = cnt - 1'b1;
                        end
                    end else begin
                        state_nxt = PRESSED;
                        cnt_nxt   = THR;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end
endmodule

// File: rtl/key_debounce_bank.sv
// Purpose : CHANNELS independent key debouncers sharing one tick strobe.
// Latency : THRESHOLD qualifying ticks per press/release (+2 clk with DEBOUNCE_SYNC_EN).
// Backpressure: none; all channels advance only on tickEn edges.
// Ports   : clk, rst_n plus key_debounce_bank_if.slave (tickEn, keyBounce in;
//           keyDeBounce, pressPulse, releasePulse, holdActive out).
// Option  : define DEBOUNCE_SYNC_EN to add a 2-flop synchroniser (reset to 1) per key.
module key_debounce_bank
    import key_debounce_bank_pkg::*;
#(
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int THRESHOLD  = DEF_THRESHOLD,
    parameter int HOLD_W     = DEF_HOLD_W,
    parameter int HOLD_TICKS = DEF_HOLD_TICKS
) (
    input  logic                clk,
    input  logic                rst_n,
    key_debounce_bank_if.slave  keys
);
    logic [CHANNELS-1:0] key_in;
    logic [CHANNELS-1:0] level, press, release_ev, hold;

`ifdef DEBOUNCE_SYNC_EN
    // Sync flops reset to the released level so reset never looks like a press.
    logic [CHANNELS-1:0] sync_q1, sync_q2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '1;
            sync_q2 <= '1;
        end else begin
            sync_q1 <= keys.keyBounce;
            sync_q2 <= sync_q1;
        end
    end

    assign key_in = sync_q2;
`else
    assign key_in = keys.keyBounce;
`endif

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        key_debounce_channel #(
            .CNT_W      (CNT_W),
            .THRESHOLD  (THRESHOLD),
            .HOLD_W     (HOLD_W),
            .HOLD_TICKS (HOLD_TICKS)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .tick_en       (keys.tickEn),
            .key_raw       (key_in[g]),
            .key_level     (level[g]),
            .press_pulse   (press[g]),
            .release_pulse (release_ev[g]),
            .hold_active   (hold[g])
        );
    end

    assign keys.keyDeBounce  = level;
    assign keys.pressPulse   = press;
    assign keys.releasePulse = release_ev;
    assign keys.holdActive   = hold;
endmodule
